// File: rtl/sha3_pad_absorb_buf.sv
// sha3_pad_absorb_buf: SHA-3 pad10*1 + rate-block assembly; in_* lane stream in (valid/ready), blk_* padded rate block out (valid/ready, first/last tags)
module sha3_pad_absorb_buf #(
  parameter int RATE_LANES = 17,
  parameter logic [7:0] DOMAIN_PAD = 8'h06
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [63:0]             in_data,
  input  logic                    in_last,
  input  logic [3:0]              in_bytes,
  output logic                    blk_valid,
  input  logic                    blk_ready,
  output logic [64*RATE_LANES-1:0] blk_data,
  output logic                    blk_first,
  output logic                    blk_last
);
  localparam int W = 64*RATE_LANES;
  localparam int CW = $clog2(RATE_LANES);
  localparam logic [W-1:0] PAD_BLK = {8'h80, {(W-16){1'b0}}, DOMAIN_PAD};
  typedef enum logic {ACCUM, EMIT} state_t;
  state_t state;
  logic [CW-1:0] lane_cnt;
  logic pad_pend, first_flag, xfer, full, n8, pad_fin;
  logic [3:0] n;
  logic [63:0] lane_w;
  logic [W-1:0] nb;
  always_comb begin
    xfer = state == ACCUM && in_valid && in_ready;
    full = lane_cnt == CW'(RATE_LANES-1);
    n = in_bytes > 4'd8 ? 4'd8 : in_bytes;
    n8 = n == 4'd8;
    pad_fin = in_last && !(n8 && full);
    lane_w = '0;
    for (int k = 0; k < 8; k++)
      lane_w[8*k+:8] = !in_last || k < int'(n) ? in_data[8*k+:8] : k == int'(n) ? DOMAIN_PAD : 8'h00;
    nb = blk_data;
    for (int i = 0; i < RATE_LANES; i++) begin
      if (i == int'(lane_cnt)) nb[64*i+:64] = lane_w;
      if (in_last && n8 && i == int'(lane_cnt) + 1) nb[64*i+:8] = DOMAIN_PAD;
    end
    if (pad_fin) nb[W-1] = 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= ACCUM;
      lane_cnt <= '0;
      blk_data <= '0;
      pad_pend <= 1'b0;
      first_flag <= 1'b1;
      in_ready <= 1'b0;
      blk_valid <= 1'b0;
      blk_first <= 1'b0;
      blk_last <= 1'b0;
    end else if (state == ACCUM) begin
      in_ready <= !(xfer && (full || in_last));
      if (xfer) begin
        blk_data <= nb;
        lane_cnt <= lane_cnt + 1'b1;
        if (full || in_last) begin
          state <= EMIT;
          blk_valid <= 1'b1;
          blk_first <= first_flag;
          blk_last <= pad_fin;
          pad_pend <= in_last && !pad_fin;
        end
      end
    end else if (blk_ready) begin
      lane_cnt <= '0;
      first_flag <= !pad_pend && blk_last;
      blk_data <= pad_pend ? PAD_BLK : '0;
      blk_first <= 1'b0;
      blk_last <= pad_pend;
      blk_valid <= pad_pend;
      in_ready <= !pad_pend;
      pad_pend <= 1'b0;
      state <= pad_pend ? EMIT : ACCUM;
    end
endmodule

// File: tb/tb_sha3_pad_absorb_buf.sv
// tb_sha3_pad_absorb_buf: directed vector bench for sha3_pad_absorb_buf
module tb_sha3_pad_absorb_buf;
  localparam int RL = 17;
  localparam int RB = 8*RL;
  localparam int W = 64*RL;
  logic clk = 0, rst_n = 0, in_valid = 0, in_last = 0, blk_ready = 0;
  logic in_ready, blk_valid, blk_first, blk_last;
  logic [63:0] in_data = '0;
  logic [3:0] in_bytes = '0;
  logic [W-1:0] blk_data;
  int nvec = 0, nerr = 0;
  typedef struct {
    logic [63:0] data;
    logic [3:0] bytes;
    logic [63:0] l0, l1;
  } vec_t;
  vec_t vt[6];
  always #5 clk = ~clk;
  sha3_pad_absorb_buf #(.RATE_LANES(RL), .DOMAIN_PAD(8'h06)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .in_bytes(in_bytes),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data),
    .blk_first(blk_first), .blk_last(blk_last)
  );
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  function automatic logic [7:0] mb(int g);
    return 8'(g*13 + 5);
  endfunction
  function automatic logic [W-1:0] exp_blk(int len, int b);
    logic [W-1:0] e = '0;
    for (int j = 0; j < RB; j++) begin
      int g = b*RB + j;
      e[8*j+:8] = g < len ? mb(g) : g == len ? 8'h06 : 8'h00;
    end
    if (b == len/RB) e[W-1] = 1'b1;
    return e;
  endfunction
  task automatic send_lane(logic [63:0] d, logic last, logic [3:0] nbytes);
    int t = 0;
    @(negedge clk);
    in_valid = 1; in_data = d; in_last = last; in_bytes = nbytes;
    while (!in_ready && t < 400) begin @(negedge clk); t++; end
    if (!in_ready) chk("in_ready timeout", {63'b0, in_ready}, 64'd1);
  endtask
  task automatic send_msg(int len);
    int nl = len == 0 ? 1 : (len + 7)/8;
    for (int k = 0; k < nl; k++) begin
      logic [63:0] d;
      int rem = len - 8*k;
      for (int j = 0; j < 8; j++) d[8*j+:8] = 8*k + j < len ? mb(8*k + j) : 8'hEE;
      send_lane(d, k == nl - 1, rem >= 8 ? 4'd8 : 4'(rem));
    end
    @(negedge clk);
    in_valid = 0; in_last = 0;
  endtask
  task automatic get_block(string tag, logic [W-1:0] e, logic ef, logic el, int stall);
    int t = 0;
    logic [W-1:0] snap;
    while (!blk_valid && t < 400) begin @(negedge clk); t++; end
    chk({tag, " valid"}, {63'b0, blk_valid}, 64'd1);
    for (int i = 0; i < RL; i++) chk($sformatf("%s lane%0d", tag, i), blk_data[64*i+:64], e[64*i+:64]);
    chk({tag, " first"}, {63'b0, blk_first}, {63'b0, ef});
    chk({tag, " last"}, {63'b0, blk_last}, {63'b0, el});
    snap = blk_data;
    for (int c = 0; c < stall; c++) begin
      @(negedge clk);
      chk($sformatf("%s hold%0d", tag, c), {63'b0, blk_valid && blk_data == snap}, 64'd1);
      chk($sformatf("%s in_ready%0d", tag, c), {63'b0, in_ready}, 64'd0);
    end
    blk_ready = 1;
    @(negedge clk);
    blk_ready = 0;
  endtask
  task automatic run_msg(string tag, int len, int stall);
    int nbk = len/RB + 1;
    fork
      send_msg(len);
      for (int b = 0; b < nbk; b++)
        get_block($sformatf("%s b%0d", tag, b), exp_blk(len, b), b == 0, b == nbk - 1, b == 0 ? stall : 0);
    join
  endtask
  task automatic run_vec(int i);
    logic [W-1:0] e = '0;
    e[63:0] = vt[i].l0;
    e[127:64] = vt[i].l1;
    e[W-1-:64] |= 64'h8000_0000_0000_0000;
    fork
      begin
        send_lane(vt[i].data, 1'b1, vt[i].bytes);
        @(negedge clk);
        in_valid = 0; in_last = 0;
      end
      get_block($sformatf("vec%0d", i), e, 1'b1, 1'b1, 0);
    join
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
  initial begin
    vt[0] = '{64'h0000_0000_0063_6261, 4'd3, 64'h0000_0000_0663_6261, 64'h0};
    vt[1] = '{64'h0, 4'd0, 64'h06, 64'h0};
    vt[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 4'd2, 64'h0000_0000_0006_FFFF, 64'h0};
    vt[3] = '{64'h1111_1111_1111_1111, 4'd7, 64'h0611_1111_1111_1111, 64'h0};
    vt[4] = '{64'h0807_0605_0403_0201, 4'd8, 64'h0807_0605_0403_0201, 64'h06};
    vt[5] = '{64'hA1B2_C3D4_E5F6_0718, 4'd12, 64'hA1B2_C3D4_E5F6_0718, 64'h06};
    repeat (2) @(negedge clk);
    chk("rst in_ready", {63'b0, in_ready}, 64'd0);
    chk("rst blk_valid", {63'b0, blk_valid}, 64'd0);
    chk("rst blk_first", {63'b0, blk_first}, 64'd0);
    chk("rst blk_last", {63'b0, blk_last}, 64'd0);
    chk("rst lane0", blk_data[63:0], 64'd0);
    rst_n = 1;
    #1 chk("rel in_ready", {63'b0, in_ready}, 64'd0);
    @(negedge clk);
    chk("post-rel in_ready", {63'b0, in_ready}, 64'd1);
    for (int i = 0; i < 6; i++) run_vec(i);
    run_msg("m135", 135, 0);
    run_msg("m136", 136, 0);
    run_msg("bp20", 20, 5);
    run_msg("m300", 300, 0);
    for (int k = 0; k < 5; k++) send_lane(64'h1234_5678_9ABC_DEF0 + 64'(k), 1'b0, 4'd8);
    @(negedge clk);
    in_valid = 0;
    chk("pre-rst lane0", {63'b0, blk_data[63:0] != 64'd0}, 64'd1);
    rst_n = 0;
    #1;
    chk("mid-rst in_ready", {63'b0, in_ready}, 64'd0);
    chk("mid-rst blk_valid", {63'b0, blk_valid}, 64'd0);
    chk("mid-rst lane0", blk_data[63:0], 64'd0);
    chk("mid-rst lane4", blk_data[319:256], 64'd0);
    @(negedge clk);
    rst_n = 1;
    run_vec(0);
    repeat (3) @(negedge clk);
    chk("idle blk_valid", {63'b0, blk_valid}, 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
